axi_bram2axis: RTL and testbench

Reads a contiguous BRAM region from address 0 and streams it out as an AXI4-Stream, with tlast on the final beat.
- Transmit-side counterpart of the stream-to-BRAM writer; used for host readback and for feeding compute results to the AXI write path.
- Reads are pipelined through a fixed BRAM read latency.
- A credit-limited output FIFO absorbs tready backpressure, so no read is ever lost or replayed.

---
 rtl/axi_bram_pkg.sv | 25 ++
 rtl/axi_b2as_fifo.sv | 46 ++++
 rtl/axi_bram2axis.sv | 137 +++++++++++++
 tb/tb_axi_bram2axis.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bram_pkg.sv
// axi_bram2axis shared types: FSM encoding, beat sizing, depth helper.
// Depth rounds up when AXI_B2AS_TKEEP_EN is defined, down otherwise.
package axi_bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd3
  } b2as_state_e;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int BYTES_PER_BEAT = DATA_WIDTH_DEF / 8;

  function automatic logic [63:0] calc_depth(
    input logic [63:0] nbytes,
    input int unsigned bpb
  );
`ifdef AXI_B2AS_TKEEP_EN
    return (nbytes + 64'(bpb) - 64'd1) / 64'(bpb);
`else
    return nbytes / 64'(bpb);
`endif
  endfunction

endpackage

// File: rtl/axi_b2as_fifo.sv
// Output FIFO for axi_bram2axis: power-of-2 entries, count output,
// simultaneous push and pop.
module axi_b2as_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign empty = (count == '0);

endmodule

// File: rtl/axi_bram2axis.sv
// Streams BRAM words 0..depth-1 out as AXI4-Stream with credit-limited reads.
// Define AXI_B2AS_TKEEP_EN to add m_axis_tkeep and ceil-rounded depth.
module axi_bram2axis
  import axi_bram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int BRAM_DELAY          = 2,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_b2as_start,
  output logic                           o_b2as_done,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2as_data_size_bytes,
  output logic                           o_b2as_rden,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_b2as_rdaddr,
  input  logic [BRAM_DATA_WIDTH-1:0]     i_b2as_rddata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]      m_axis_tdata,
`ifdef AXI_B2AS_TKEEP_EN
  output logic [AXI_DATA_WIDTH/8-1:0]    m_axis_tkeep,
`endif
  output logic                           m_axis_tlast
);

  localparam int BPB = BRAM_DATA_WIDTH / 8;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW1 = BRAM_ADDR_WIDTH + 1;

  b2as_state_e           state;
  logic [AW1-1:0]        depth;
  logic [AW1-1:0]        new_depth;
  logic [AW1-1:0]        rd_addr;
  logic [AW1-1:0]        ret_cnt;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fcount;
  logic [CW:0]           used;
  logic [BRAM_DELAY-1:0] pipe;
  logic                  push;
  logic                  pop;
  logic                  fempty;
  logic                  push_last;
  logic                  last_hs;
  logic [BRAM_DATA_WIDTH:0] head;

  assign new_depth = AW1'(calc_depth(64'(i_b2as_data_size_bytes), BPB));
  assign used      = {1'b0, inflight} + {1'b0, fcount};

  // Credit covers both reads still in the BRAM pipe and words parked in the FIFO.
  assign o_b2as_rden   = (state == READ) && (rd_addr < depth) &&
                         (used < (CW+1)'(FIFO_DEPTH));
  assign o_b2as_rdaddr = rd_addr[BRAM_ADDR_WIDTH-1:0];

  assign push      = pipe[BRAM_DELAY-1];
  assign push_last = (ret_cnt == depth - AW1'(1));

  assign m_axis_tvalid = !fempty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = head[BRAM_DATA_WIDTH];
  assign m_axis_tdata  = head[BRAM_DATA_WIDTH-1:0];
  assign last_hs       = pop && m_axis_tlast;

  axi_b2as_fifo #(
    .W     (BRAM_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({push_last, i_b2as_rddata}),
    .pop   (pop),
    .dout  (head),
    .empty (fempty),
    .count (fcount)
  );

`ifdef AXI_B2AS_TKEEP_EN
  localparam int RW = $clog2(BPB);
  logic [RW-1:0] rem;

  assign m_axis_tkeep = (m_axis_tlast && rem != '0) ?
                        ~({BPB{1'b1}} << rem) : {BPB{1'b1}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      depth       <= '0;
      rd_addr     <= '0;
      ret_cnt     <= '0;
      inflight    <= '0;
      pipe        <= '0;
      o_b2as_done <= 1'b1;
`ifdef AXI_B2AS_TKEEP_EN
      rem         <= '0;
`endif
    end else begin
      pipe     <= BRAM_DELAY'({pipe, o_b2as_rden});
      inflight <= inflight + CW'(o_b2as_rden) - CW'(push);
      if (o_b2as_rden) rd_addr <= rd_addr + AW1'(1);
      if (push)        ret_cnt <= ret_cnt + AW1'(1);
      unique case (state)
        IDLE: begin
          if (i_b2as_start) begin
            depth       <= new_depth;
            rd_addr     <= '0;
            ret_cnt     <= '0;
            o_b2as_done <= 1'b0;
            state       <= (new_depth != '0) ? READ : FLUSH;
`ifdef AXI_B2AS_TKEEP_EN
            rem         <= i_b2as_data_size_bytes[RW-1:0];
`endif
          end
        end
        READ: begin
          if (rd_addr == depth) state <= FLUSH;
        end
        FLUSH: begin
          // Reads return in order, so the tlast handshake is the final event.
          if (depth == '0 || last_hs) begin
            state       <= IDLE;
            o_b2as_done <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_b2as_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bram2axis.sv
// Directed bench for axi_bram2axis with a behavioural BRAM of fixed latency.
// Build with AXI_B2AS_TKEEP_EN defined to exercise the tkeep variant.
module tb_axi_bram2axis;

  localparam int DW  = 128;
  localparam int SW  = 32;
  localparam int AW  = 32;
  localparam int DLY = 2;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic [SW-1:0] size;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
`ifdef AXI_B2AS_TKEEP_EN
  logic [DW/8-1:0] tkeep;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_bram2axis #(
    .AXI_DATA_WIDTH      (DW),
    .AXI_XFER_SIZE_WIDTH (SW),
    .BRAM_ADDR_WIDTH     (AW),
    .BRAM_DATA_WIDTH     (DW),
    .BRAM_DELAY          (DLY),
    .FIFO_DEPTH          (FD)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_b2as_start           (start),
    .o_b2as_done            (done),
    .i_b2as_data_size_bytes (size),
    .o_b2as_rden            (rden),
    .o_b2as_rdaddr          (rdaddr),
    .i_b2as_rddata          (rddata),
    .m_axis_tvalid          (tvalid),
    .m_axis_tready          (tready),
    .m_axis_tdata           (tdata),
`ifdef AXI_B2AS_TKEEP_EN
    .m_axis_tkeep           (tkeep),
`endif
    .m_axis_tlast           (tlast)
  );

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    return {a ^ 32'h1234_5678, ~a, a * 32'd3, 32'hC0DE_0000 | a};
  endfunction

  // BRAM model: data for the address presented with rden appears DLY cycles later
  logic [AW-1:0] bq [DLY];
  always @(posedge clk) begin
    bq[0] <= rdaddr;
    for (int k = 1; k < DLY; k++) bq[k] <= bq[k-1];
  end
  assign rddata = bram_word(bq[DLY-1]);

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int            cyc = 0;
  bit            armed = 0;
  int            rdq [$];
  logic [DW-1:0] bdq [$];
  bit            blq [$];
  logic [15:0]   bkq [$];
  int            hold_err;
  int            max_out;
  int            first_v;
  int            last_hs;
  int            done_at;
  bit            pstall;
  logic [DW-1:0] pdata;
  logic          plast;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      if (pstall && (!tvalid || tdata !== pdata || tlast !== plast))
        hold_err++;
      if (rden) rdq.push_back(int'(rdaddr));
      if (rdq.size() - bdq.size() > max_out)
        max_out = rdq.size() - bdq.size();
      if (tvalid && first_v < 0) first_v = cyc;
      if (tvalid && tready) begin
        bdq.push_back(tdata);
        blq.push_back(tlast);
`ifdef AXI_B2AS_TKEEP_EN
        bkq.push_back(16'(tkeep));
`endif
        if (tlast) last_hs = cyc;
      end
      if (done && done_at < 0) done_at = cyc;
      pstall = tvalid && !tready;
      pdata  = tdata;
      plast  = tlast;
    end
  end

  // mode 0: ready high, 1: ready toggles, 2: ready low 20 cycles, 3: restart pulse
  task automatic do_xfer(input string tag, input int nbytes,
                         input int mode, input int n_exp);
    int st_reads;
    int start_cyc;
    int e_addr;
    int e_data;
    int e_last;
    st_reads = -1;
    rdq.delete(); bdq.delete(); blq.delete(); bkq.delete();
    hold_err = 0; max_out = 0; first_v = -1;
    last_hs = -1; done_at = -1; pstall = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    size   = SW'(nbytes);
    tready = (mode != 2);
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    armed     = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      case (mode)
        1:       tready = c[0];
        2:       tready = (c >= 20);
        default: tready = 1'b1;
      endcase
      if (mode == 3) begin
        start = (c == 3);
        size  = 32'd512;
      end
      if (c == 19) st_reads = rdq.size();
      if (done_at >= 0) break;
    end
    armed = 1'b0;
    start = 1'b0;
    tready = 1'b1;
    e_addr = 0; e_data = 0; e_last = 0;
    for (int i = 0; i < rdq.size(); i++)
      if (rdq[i] != i) e_addr++;
    for (int i = 0; i < bdq.size(); i++) begin
      if (bdq[i] !== bram_word(AW'(i))) e_data++;
      if (blq[i] != (i == n_exp - 1)) e_last++;
    end
    chk({tag, "_done"},   done_at >= 0, 1);
    chk({tag, "_beats"},  bdq.size(), n_exp);
    chk({tag, "_reads"},  rdq.size(), n_exp);
    chk({tag, "_addr"},   e_addr, 0);
    chk({tag, "_data"},   e_data, 0);
    chk({tag, "_last"},   e_last, 0);
    chk({tag, "_hold"},   hold_err, 0);
    chk({tag, "_credit"}, max_out <= FD, 1);
    if (n_exp > 0) begin
      chk({tag, "_done_lat"}, done_at - last_hs, 1);
      if (mode == 0)
        chk({tag, "_first_lat"}, first_v - start_cyc - 1, 1 + DLY);
    end else begin
      chk({tag, "_zero_done"}, done_at - start_cyc, 2);
      chk({tag, "_zero_valid"}, first_v < 0, 1);
    end
    if (mode == 2)
      chk({tag, "_stall_reads"}, st_reads, (n_exp < FD) ? n_exp : FD);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    size   = '0;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",   done,   1);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_rden",   rden,   0);
    chk("rst_tlast",  tlast,  0);
    rst = 1'b0;

    do_xfer("t1",  256, 0, 16);
    do_xfer("t2",  128, 1, 8);
    do_xfer("t3a", 256, 2, 16);
    do_xfer("t3b", 64,  2, 4);
`ifdef AXI_B2AS_TKEEP_EN
    do_xfer("t4",  8,   0, 1);
    if (bkq.size() > 0) chk("t4_tkeep", bkq[0], 16'h00FF);
    else chk("t4_tkeep_seen", bkq.size(), 1);
`else
    do_xfer("t4",  8,   0, 0);
`endif

    @(posedge clk); #1;
    start  = 1'b1;
    size   = 32'd512;
    tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_mid_valid", tvalid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_tvalid", tvalid, 0);
    chk("t5_rst_rden",   rden,   0);
    chk("t5_rst_done",   done,   1);
    do_xfer("t5",  32,  0, 2);

    do_xfer("t6",  256, 3, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
